// File: rtl/fir_tx_serializer.sv
// rtl/fir_tx_serializer.sv - buffers reduced FIR results and sends each as two UART bytes, MSB first
// Define FIR_TX_SAT_EN to clamp out-of-range samples instead of wrapping the bit window.
module fir_tx_serializer #(
    parameter int IN_W      = 38,
    parameter int OUT_W     = 16,
    parameter int LSB_SHIFT = 8,
    parameter int DEPTH     = 8,
    parameter int AW        = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [IN_W-1:0] fir_out_i,
    input  logic            fir_valid_i,
    input  logic            tx_busy_i,
    output logic            tx_start_o,
    output logic [7:0]      tx_data_o,
    output logic [AW:0]     fifo_count_o,
    output logic            overflow_o,
    output logic            sat_flag_o,
    output logic            idle_o
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_HI_START,
        ST_HI_WAIT,
        ST_LO_START,
        ST_LO_WAIT
    } state_t;

    logic [OUT_W-1:0] word_d;
    logic             sat_d;
    logic             unused_bits;

`ifdef FIR_TX_SAT_EN
    localparam int TOP_W = IN_W - (LSB_SHIFT + OUT_W - 1);
    logic [TOP_W-1:0] top_bits;

    // The sign bit of the window plus everything above it must agree for the value to fit.
    always_comb begin
        top_bits = fir_out_i[IN_W-1:LSB_SHIFT+OUT_W-1];
        sat_d    = !((&top_bits) || !(|top_bits));
        word_d   = fir_out_i[LSB_SHIFT+OUT_W-1:LSB_SHIFT];
        if (sat_d) begin
            word_d = fir_out_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
    assign unused_bits = ^fir_out_i[LSB_SHIFT-1:0];
`else
    assign word_d      = fir_out_i[LSB_SHIFT+OUT_W-1:LSB_SHIFT];
    assign sat_d       = 1'b0;
    assign unused_bits = ^{fir_out_i[IN_W-1:LSB_SHIFT+OUT_W], fir_out_i[LSB_SHIFT-1:0]};
`endif

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             overflow_q;
    logic             sat_q;
    logic             push;
    logic             pop;

    state_t           state_q;
    state_t           state_d;
    logic             guard_q;
    logic [OUT_W-1:0] hold_q;
    logic             tx_start_q;
    logic [7:0]       tx_data_q;
    logic             idle_q;
    logic             start_fire;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign pop  = (state_q == ST_POP);
    assign push = fir_valid_i && ((count_q < DEPTH_W) || pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (sat_d) begin
                    sat_q <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (fir_valid_i && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign start_fire = ((state_q == ST_HI_START) || (state_q == ST_LO_START)) && !tx_busy_i;

    // guard_q marks the first WAIT cycle, when busy has not yet risen in response to the start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (count_q != '0) state_d = ST_POP;
            ST_POP:      state_d = ST_HI_START;
            ST_HI_START: if (!tx_busy_i) state_d = ST_HI_WAIT;
            ST_HI_WAIT:  if (!guard_q && !tx_busy_i) state_d = ST_LO_START;
            ST_LO_START: if (!tx_busy_i) state_d = ST_LO_WAIT;
            ST_LO_WAIT: begin
                if (!guard_q && !tx_busy_i) begin
                    state_d = (count_q != '0) ? ST_POP : ST_IDLE;
                end
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            guard_q    <= 1'b0;
            hold_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            guard_q    <= start_fire;
            tx_start_q <= start_fire;
            idle_q     <= (count_d == '0) && (state_d == ST_IDLE);
            if (pop) begin
                hold_q    <= mem_q[rd_ptr_q];
                tx_data_q <= mem_q[rd_ptr_q][OUT_W-1 -: 8];
            end
            if ((state_q == ST_HI_WAIT) && (state_d == ST_LO_START)) begin
                tx_data_q <= hold_q[7:0];
            end
        end
    end

    assign tx_start_o   = tx_start_q;
    assign tx_data_o    = tx_data_q;
    assign fifo_count_o = count_q;
    assign overflow_o   = overflow_q;
    assign sat_flag_o   = sat_q;
    assign idle_o       = idle_q;

endmodule
